spi_frame_sequencer: RTL and testbench

Command/response sequencer that sits directly upstream of the 16-bit SPI master. It buffers outgoing 16-bit words from the datapath (multiplier result / UART command path) in a TX FIFO and launches one SPI frame per word. It captures each received frame into an RX FIFO and enforces the inter-frame gap so every start pulse lands while the master is idle. A watchdog flags any frame that never completes.

---
 rtl/spi_seq_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 56 +++++
 rtl/spi_frame_sequencer.sv | 166 ++++++++++++++++
 tb/tb_spi_frame_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_seq_pkg.sv
// Shared types and width helpers for the SPI frame sequencer.
package spi_seq_pkg;

  localparam int DATA_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  // Bits needed to index/count 0..n-1 (at least 1 bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold an occupancy of 0..depth.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers/count; head is combinational
// and reads as zero while empty.
module sync_fifo
  import spi_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              head,
  output logic                          full,
  output logic                          empty,
  output logic [occ_width(DEPTH)-1:0]   count
);

  localparam int PTR_W = cnt_width(DEPTH);
  localparam int CNT_W = occ_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/spi_frame_sequencer.sv
// Buffers words into SPI frames, captures responses, enforces the
// inter-frame gap and watches for frames that never complete.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   IDLE      | wait for a TX word and (if capturing) RX space
//   LAUNCH    | one-cycle start pulse, pop TX, latch rx capture flag
//   WAIT_DONE | wait for rising edge of master done, or watchdog
//   GAP       | hold off GAP_CYCLES so the master is idle at next start
module spi_frame_sequencer
  import spi_seq_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int DEPTH          = 4,
  parameter int GAP_CYCLES     = 64,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  input  logic                  cfg_rx_en,
  input  logic                  clear_err,
  output logic                  spi_tx_start,
  output logic                  spi_rx_start,
  output logic [DATA_WIDTH-1:0] spi_tx_data,
  input  logic                  spi_tx_done,
  input  logic                  spi_rx_valid,
  input  logic [DATA_WIDTH-1:0] spi_rx_data,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int GAP_W = cnt_width(GAP_CYCLES);
  localparam int TO_W  = cnt_width(TIMEOUT_CYCLES);
  localparam int CNT_W = occ_width(DEPTH);

  state_t                state;
  state_t                state_nxt;
  logic                  done_d;
  logic                  done_rise;
  logic                  rx_cap;
  logic [GAP_W-1:0]      gap_cnt;
  logic [TO_W-1:0]       to_cnt;
  logic                  to_hit;
  logic                  to_set;
  logic                  load_tx;

  logic                  tx_push;
  logic                  tx_pop;
  logic [DATA_WIDTH-1:0] tx_head;
  logic                  tx_full;
  logic                  tx_empty;
  logic [CNT_W-1:0]      tx_count_unused;

  logic                  rx_push;
  logic                  rx_pop;
  logic                  rx_full;
  logic                  rx_empty;
  logic [CNT_W-1:0]      rx_count_unused;

  // The master's rx_valid mirrors its done level; capture keys off the done edge.
  logic                  unused_rx_valid;
  assign unused_rx_valid = spi_rx_valid;

  assign in_ready  = !tx_full;
  assign out_valid = !rx_empty;
  assign tx_push   = in_valid && in_ready;
  assign rx_pop    = out_valid && out_ready;
  assign busy      = (state != IDLE);
  assign done_rise = spi_tx_done && !done_d;
  assign to_hit    = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data (in_data),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count_unused)
  );

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (spi_rx_data),
    .pop       (rx_pop),
    .head      (out_data),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count_unused)
  );

  always_comb begin
    state_nxt    = state;
    tx_pop       = 1'b0;
    rx_push      = 1'b0;
    to_set       = 1'b0;
    load_tx      = 1'b0;
    spi_tx_start = 1'b0;
    spi_rx_start = 1'b0;
    case (state)
      IDLE: begin
        if (!tx_empty && (!cfg_rx_en || !rx_full)) begin
          state_nxt = LAUNCH;
          load_tx   = 1'b1;
        end
      end
      LAUNCH: begin
        spi_tx_start = 1'b1;
        spi_rx_start = cfg_rx_en;
        tx_pop       = 1'b1;
        state_nxt    = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_rise) begin
          rx_push   = rx_cap;
          state_nxt = GAP;
        end else if (to_hit) begin
          to_set    = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The payload is loaded on entry to LAUNCH so it is valid alongside the start pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      done_d      <= 1'b0;
      rx_cap      <= 1'b0;
      gap_cnt     <= '0;
      to_cnt      <= '0;
      spi_tx_data <= '0;
      timeout_err <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_d <= spi_tx_done;
      if (load_tx) spi_tx_data <= tx_head;
      if (state == LAUNCH) begin
        rx_cap <= cfg_rx_en;
        to_cnt <= '0;
      end else if (state == WAIT_DONE) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
      if (state == GAP) gap_cnt <= gap_cnt - GAP_W'(1);
      else              gap_cnt <= GAP_W'(GAP_CYCLES - 1);
      if (to_set)         timeout_err <= 1'b1;
      else if (clear_err) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Directed bench for spi_frame_sequencer with a behavioural SPI master.
module tb_spi_frame_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready = 1'b0;
  logic        cfg_rx_en = 1'b0;
  logic        clear_err = 1'b0;
  logic        spi_tx_start;
  logic        spi_rx_start;
  logic [15:0] spi_tx_data;
  logic        spi_tx_done = 1'b0;
  logic        spi_rx_valid = 1'b0;
  logic [15:0] spi_rx_data = '0;
  logic        busy;
  logic        timeout_err;

  spi_frame_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .cfg_rx_en    (cfg_rx_en),
    .clear_err    (clear_err),
    .spi_tx_start (spi_tx_start),
    .spi_rx_start (spi_rx_start),
    .spi_tx_data  (spi_tx_data),
    .spi_tx_done  (spi_tx_done),
    .spi_rx_valid (spi_rx_valid),
    .spi_rx_data  (spi_rx_data),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural master: responds with payload ^ 16'h9999 after master_delay cycles.
  int          master_delay = 40;
  bit          master_hang = 1'b0;
  int          pend = 0;
  bit          active = 1'b0;
  logic [15:0] cur_rsp = '0;
  logic [15:0] tx_log[$];
  logic        rxs_log[$];
  int          launch_cyc_q[$];
  int          done_cyc_q[$];

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      spi_tx_done  = 1'b0;
      spi_rx_valid = 1'b0;
      active       = 1'b0;
      pend         = 0;
    end else if (spi_tx_start) begin
      spi_tx_done  = 1'b0;
      spi_rx_valid = 1'b0;
      tx_log.push_back(spi_tx_data);
      rxs_log.push_back(spi_rx_start);
      launch_cyc_q.push_back(cyc);
      cur_rsp = spi_tx_data ^ 16'h9999;
      pend    = master_delay;
      active  = !master_hang;
    end else if (active) begin
      pend = pend - 1;
      if (pend == 0) begin
        spi_tx_done  = 1'b1;
        spi_rx_valid = 1'b1;
        spi_rx_data  = cur_rsp;
        done_cyc_q.push_back(cyc);
        active = 1'b0;
      end
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // All tasks enter and leave at a negedge.
  task automatic push_word(input logic [15:0] d, input int budget, output bit ok);
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < budget; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic pop_word(output logic [15:0] d, input int budget, output bit ok);
    ok = 1'b0;
    d  = '0;
    for (int i = 0; i < budget; i++) begin
      if (out_valid) begin
        d = out_data;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_launch(input int base, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx_log.size() > base) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [15:0] data;
    logic        rx_en;
    logic        exp_rx_start;
    logic        exp_out_valid;
    logic [15:0] exp_out_data;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit          ok;
    int          base;
    int          dbase;
    logic [15:0] d;
    logic [15:0] bw[6];

    vecs[0] = '{16'hA5C3, 1'b1, 1'b1, 1'b1, 16'h3C5A};
    vecs[1] = '{16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[2] = '{16'h1234, 1'b1, 1'b1, 1'b1, 16'h8BAD};
    vecs[3] = '{16'hFFFF, 1'b1, 1'b1, 1'b1, 16'h6666};
    vecs[4] = '{16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_tx_start", spi_tx_start, 0);
    chk("rst_rx_start", spi_rx_start, 0);
    chk("rst_tx_data", spi_tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    reset = 1'b1;
    @(negedge clk);

    // Single frame: exact latency, pulse width and gap timing
    cfg_rx_en = 1'b1;
    push_word(16'hA5C3, 5, ok);
    chk("t1_push", ok, 1);
    @(negedge clk);
    chk("t1_latency_start", spi_tx_start, 1);
    chk("t1_tx_data", spi_tx_data, 16'hA5C3);
    chk("t1_rx_start", spi_rx_start, 1);
    @(negedge clk);
    chk("t1_start_one_cycle", spi_tx_start, 0);
    chk("t1_tx_data_hold", spi_tx_data, 16'hA5C3);
    wait_idle(500, ok);
    chk("t1_idle_wait", ok, 1);
    if (ok && done_cyc_q.size() > 0)
      chk("t1_gap_len", cyc - done_cyc_q[done_cyc_q.size()-1], 65);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_data", out_data, 16'h3C5A);
    pop_word(d, 5, ok);
    chk("t1_pop", ok, 1);
    chk("t1_rx_empty", out_valid, 0);

    // Table of single frames, with and without capture
    for (int i = 0; i < 5; i++) begin
      cfg_rx_en = vecs[i].rx_en;
      base = tx_log.size();
      push_word(vecs[i].data, 5, ok);
      chk("vec_push", ok, 1);
      wait_launch(base, 20, ok);
      chk("vec_launch", ok, 1);
      if (ok) begin
        chk("vec_tx_data", tx_log[base], vecs[i].data);
        chk("vec_rx_start", rxs_log[base], vecs[i].exp_rx_start);
      end
      wait_idle(500, ok);
      chk("vec_idle", ok, 1);
      chk("vec_out_valid", out_valid, vecs[i].exp_out_valid);
      if (vecs[i].exp_out_valid) begin
        chk("vec_out_data", out_data, vecs[i].exp_out_data);
        pop_word(d, 5, ok);
        chk("vec_pop", ok, 1);
      end
    end

    // Burst: 5 words fill the FIFO behind the first launch, 6th waits for a pop
    cfg_rx_en = 1'b0;
    base  = tx_log.size();
    dbase = done_cyc_q.size();
    for (int j = 0; j < 6; j++) bw[j] = 16'hC100 + 16'(j);
    for (int j = 0; j < 5; j++) begin
      push_word(bw[j], 1, ok);
      chk("burst_push_immediate", ok, 1);
    end
    chk("burst_full_in_ready", in_ready, 0);
    push_word(bw[5], 500, ok);
    chk("burst_push6", ok, 1);
    chk("burst_push6_after_pop", tx_log.size() - base, 2);
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (done_cyc_q.size() - dbase >= 6 && !busy) break;
    end
    chk("burst_launch_count", tx_log.size() - base, 6);
    chk("burst_done_count", done_cyc_q.size() - dbase, 6);
    if (tx_log.size() - base == 6 && done_cyc_q.size() - dbase == 6) begin
      for (int j = 0; j < 6; j++) chk("burst_order", tx_log[base+j], bw[j]);
      for (int j = 1; j < 6; j++)
        chk("burst_gap_ge65", (launch_cyc_q[base+j] - done_cyc_q[dbase+j-1]) >= 65, 1);
    end
    chk("burst_rx_empty", out_valid, 0);

    // RX backpressure: 4 frames fill RX, then the FSM parks in IDLE
    cfg_rx_en = 1'b1;
    out_ready = 1'b0;
    base  = tx_log.size();
    dbase = done_cyc_q.size();
    for (int j = 0; j < 6; j++) bw[j] = 16'hB000 + 16'(j);
    for (int j = 0; j < 6; j++) begin
      push_word(bw[j], 1500, ok);
      chk("bp_push", ok, 1);
    end
    repeat (400) @(negedge clk);
    chk("bp_launches", tx_log.size() - base, 4);
    chk("bp_dones", done_cyc_q.size() - dbase, 4);
    chk("bp_idle", busy, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_head", out_data, bw[0] ^ 16'h9999);
    pop_word(d, 5, ok);
    chk("bp_pulse_pop", ok, 1);
    wait_launch(base + 4, 10, ok);
    chk("bp_5th_launch", ok, 1);
    if (ok) chk("bp_5th_data", tx_log[base+4], bw[4]);
    for (int j = 1; j < 6; j++) begin
      pop_word(d, 600, ok);
      chk("bp_drain_pop", ok, 1);
      chk("bp_drain_data", d, bw[j] ^ 16'h9999);
    end
    wait_idle(500, ok);
    chk("bp_final_idle", ok, 1);

    // Watchdog: master never completes
    master_hang = 1'b1;
    cfg_rx_en = 1'b1;
    base = tx_log.size();
    push_word(16'h7E57, 5, ok);
    chk("to_push", ok, 1);
    wait_launch(base, 20, ok);
    chk("to_launch", ok, 1);
    repeat (2048) @(negedge clk);
    chk("to_not_yet", timeout_err, 0);
    chk("to_still_waiting", busy, 1);
    @(negedge clk);
    chk("to_set", timeout_err, 1);
    master_hang = 1'b0;
    wait_idle(200, ok);
    chk("to_gap_idle", ok, 1);
    chk("to_no_rx_push", out_valid, 0);
    base = tx_log.size();
    push_word(16'h5A5A, 5, ok);
    chk("to_next_push", ok, 1);
    wait_launch(base, 20, ok);
    chk("to_next_launch", ok, 1);
    if (ok) chk("to_next_data", tx_log[base], 16'h5A5A);
    wait_idle(500, ok);
    chk("to_sticky", timeout_err, 1);
    chk("to_next_rx", out_data, 16'hC3C3);
    pop_word(d, 5, ok);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    chk("to_cleared", timeout_err, 0);

    // Reset mid-frame with RX holding data and two words queued
    cfg_rx_en = 1'b1;
    base = tx_log.size();
    push_word(16'hD00D, 5, ok);
    wait_launch(base, 20, ok);
    wait_idle(500, ok);
    chk("rm_rx_loaded", out_valid, 1);
    base = tx_log.size();
    push_word(16'hD001, 5, ok);
    push_word(16'hD002, 5, ok);
    push_word(16'hD003, 5, ok);
    chk("rm_queued", ok, 1);
    wait_launch(base, 20, ok);
    repeat (5) @(negedge clk);
    chk("rm_mid_frame", busy, 1);
    reset = 1'b0;
    #1;
    chk("rm_busy", busy, 0);
    chk("rm_tx_start", spi_tx_start, 0);
    chk("rm_rx_start", spi_rx_start, 0);
    chk("rm_tx_data", spi_tx_data, 0);
    chk("rm_timeout_err", timeout_err, 0);
    chk("rm_out_valid", out_valid, 0);
    chk("rm_out_data", out_data, 0);
    chk("rm_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    base = tx_log.size();
    repeat (200) @(negedge clk);
    chk("rm_no_launch", tx_log.size() - base, 0);
    chk("rm_idle", busy, 0);
    push_word(16'h0F0F, 5, ok);
    wait_launch(base, 20, ok);
    chk("rm_new_launch", ok, 1);
    if (ok) chk("rm_new_data", tx_log[base], 16'h0F0F);
    wait_idle(500, ok);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
